// File: rtl/iseq_loader.sv
// Instruction-sequence loader: steers host words into instr0/instr1 FIFOs, packs 16-beat
// write-data bursts, and launches the sequence. Optional counters: ISEQ_LOADER_STATS_EN.
module iseq_loader #(
  parameter logic [3:0]  OP_END    = 4'hF,
  parameter logic [3:0]  OP_WRDATA = 4'hE,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         instr0_fifo_wr,
  input  logic         instr0_fifo_full,
  output logic         instr1_fifo_wr,
  input  logic         instr1_fifo_full,
  output logic [31:0]  instr_fifo_din,
  output logic         wrdata_fifo_wr,
  input  logic         wrdata_fifo_full,
  output logic [511:0] wrdata_fifo_din,
  output logic         process_iseq,
  input  logic         dispatcher_busy,
  output logic         loader_idle
`ifdef ISEQ_LOADER_STATS_EN
  ,
  output logic [15:0]  stat_iseq_cnt,
  output logic [31:0]  stat_instr_cnt
`endif
);

  typedef enum logic [2:0] {
    StInstr,
    StWrdata,
    StPad,
    StLaunch,
    StWaitHi,
    StWaitLo
  } state_e;

  state_e     state_q;
  logic       slot_q;
  logic [3:0] beat_q;
  logic       alive_q;
  logic       accept;
  logic [3:0] opcode;

  assign opcode = rx_data[31:28];
  assign accept = rx_valid & rx_ready;

  // alive_q keeps rx_ready low while reset is asserted and for the first cycle after it.
  always_comb begin
    rx_ready = 1'b0;
    if (alive_q) begin
      unique case (state_q)
        StInstr:  rx_ready = slot_q ? !instr1_fifo_full : !instr0_fifo_full;
        StWrdata: rx_ready = (beat_q != 4'd15) || !wrdata_fifo_full;
        default:  rx_ready = 1'b0;
      endcase
    end
  end

  assign loader_idle = alive_q && (state_q == StInstr) && !slot_q && (beat_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StInstr;
      slot_q          <= 1'b0;
      beat_q          <= 4'd0;
      alive_q         <= 1'b0;
      instr0_fifo_wr  <= 1'b0;
      instr1_fifo_wr  <= 1'b0;
      instr_fifo_din  <= 32'd0;
      wrdata_fifo_wr  <= 1'b0;
      wrdata_fifo_din <= 512'd0;
      process_iseq    <= 1'b0;
    end else begin
      alive_q        <= 1'b1;
      instr0_fifo_wr <= 1'b0;
      instr1_fifo_wr <= 1'b0;
      wrdata_fifo_wr <= 1'b0;
      unique case (state_q)
        StInstr: begin
          if (accept) begin
            if (opcode == OP_END) begin
              if (slot_q) begin
                state_q <= StPad;
              end else begin
                state_q      <= StLaunch;
                process_iseq <= 1'b1;
              end
            end else if (opcode == OP_WRDATA) begin
              state_q <= StWrdata;
              beat_q  <= 4'd0;
            end else begin
              instr_fifo_din <= rx_data;
              instr0_fifo_wr <= !slot_q;
              instr1_fifo_wr <= slot_q;
              slot_q         <= !slot_q;
            end
          end
        end
        StWrdata: begin
          if (accept) begin
            wrdata_fifo_din[{beat_q, 5'b0} +: 32] <= rx_data;
            beat_q <= beat_q + 4'd1;
            if (beat_q == 4'd15) begin
              wrdata_fifo_wr <= 1'b1;
              state_q        <= StInstr;
            end
          end
        end
        StPad: begin
          if (!instr1_fifo_full) begin
            instr_fifo_din <= NOP_INSTR;
            instr1_fifo_wr <= 1'b1;
            slot_q         <= 1'b0;
            state_q        <= StLaunch;
          end
        end
        StLaunch: begin
          // Arriving from the pad path the pulse is raised here, one cycle after the pad push.
          if (process_iseq) begin
            process_iseq <= 1'b0;
            state_q      <= StWaitHi;
          end else begin
            process_iseq <= 1'b1;
          end
        end
        StWaitHi: if (dispatcher_busy) state_q <= StWaitLo;
        StWaitLo: if (!dispatcher_busy) state_q <= StInstr;
        default:  state_q <= StInstr;
      endcase
    end
  end

`ifdef ISEQ_LOADER_STATS_EN
  logic launch_done;
  logic instr_store;

  assign launch_done = (state_q == StLaunch) && process_iseq;
  assign instr_store = accept && (state_q == StInstr) && (opcode != OP_END) &&
                       (opcode != OP_WRDATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_iseq_cnt  <= 16'd0;
      stat_instr_cnt <= 32'd0;
    end else begin
      if (launch_done) stat_iseq_cnt <= stat_iseq_cnt + 16'd1;
      if (instr_store) stat_instr_cnt <= stat_instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iseq_loader.sv
// Self-checking bench for iseq_loader: expected FIFO pushes are queued at stimulus time
// and popped by a monitor as the DUT pushes.
module tb_iseq_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  rx_data = 32'd0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic         instr0_fifo_wr;
  logic         instr0_fifo_full = 1'b0;
  logic         instr1_fifo_wr;
  logic         instr1_fifo_full = 1'b0;
  logic [31:0]  instr_fifo_din;
  logic         wrdata_fifo_wr;
  logic         wrdata_fifo_full = 1'b0;
  logic [511:0] wrdata_fifo_din;
  logic         process_iseq;
  logic         dispatcher_busy = 1'b0;
  logic         loader_idle;
`ifdef ISEQ_LOADER_STATS_EN
  logic [15:0]  stat_iseq_cnt;
  logic [31:0]  stat_instr_cnt;
`endif

  iseq_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .instr0_fifo_wr   (instr0_fifo_wr),
    .instr0_fifo_full (instr0_fifo_full),
    .instr1_fifo_wr   (instr1_fifo_wr),
    .instr1_fifo_full (instr1_fifo_full),
    .instr_fifo_din   (instr_fifo_din),
    .wrdata_fifo_wr   (wrdata_fifo_wr),
    .wrdata_fifo_full (wrdata_fifo_full),
    .wrdata_fifo_din  (wrdata_fifo_din),
    .process_iseq     (process_iseq),
    .dispatcher_busy  (dispatcher_busy),
    .loader_idle      (loader_idle)
`ifdef ISEQ_LOADER_STATS_EN
    ,
    .stat_iseq_cnt    (stat_iseq_cnt),
    .stat_instr_cnt   (stat_instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_launch = 0;
  int n_instr_push = 0;
  int last_instr_cyc = -1;
  int launch_cyc = -1;

  logic [31:0]  exp0[$];
  logic [31:0]  exp1[$];
  logic [511:0] expw[$];
  logic [31:0]  mon_e;
  logic [511:0] mon_w;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] END_W = 32'hF000_0000;
  localparam logic [31:0] HDR_W = 32'hE000_0000;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every push must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr0_fifo_wr) begin
        n_instr_push++;
        last_instr_cyc = cyc;
        n_checks++;
        if (exp0.size() == 0) begin
          n_fail++;
          $display("FAIL instr0_push: got %h, expected no push", instr_fifo_din);
        end else begin
          mon_e = exp0.pop_front();
          if (instr_fifo_din !== mon_e) begin
            n_fail++;
            $display("FAIL instr0_data: got %h, expected %h", instr_fifo_din, mon_e);
          end
        end
      end
      if (instr1_fifo_wr) begin
        n_instr_push++;
        last_instr_cyc = cyc;
        n_checks++;
        if (exp1.size() == 0) begin
          n_fail++;
          $display("FAIL instr1_push: got %h, expected no push", instr_fifo_din);
        end else begin
          mon_e = exp1.pop_front();
          if (instr_fifo_din !== mon_e) begin
            n_fail++;
            $display("FAIL instr1_data: got %h, expected %h", instr_fifo_din, mon_e);
          end
        end
      end
      if (wrdata_fifo_wr) begin
        n_checks++;
        if (expw.size() == 0) begin
          n_fail++;
          $display("FAIL wrdata_push: unexpected push, got %h", wrdata_fifo_din[63:0]);
        end else begin
          mon_w = expw.pop_front();
          if (wrdata_fifo_din !== mon_w) begin
            n_fail++;
            $display("FAIL wrdata_data: got lo %h hi %h, expected lo %h hi %h",
                     wrdata_fifo_din[63:0], wrdata_fifo_din[511:448], mon_w[63:0],
                     mon_w[511:448]);
          end
        end
      end
      if (process_iseq) begin
        n_launch++;
        launch_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    bit done = 1'b0;
    rx_data  = w;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_data  = $urandom();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted, rx_ready got 0 expected 1", w);
    end
  endtask

  // Plays the dispatcher: wait for the pulse, hold busy, and check the host stays stalled.
  task automatic run_dispatch();
    bit seen = 1'b0;
    bit leak = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = process_iseq;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL launch_timeout: process_iseq got 0 expected 1");
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    if (rx_ready !== 1'b0) leak = 1'b1;
    @(posedge clk);
    #1;
    dispatcher_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) leak = 1'b1;
      @(posedge clk);
      #1;
    end
    dispatcher_busy = 1'b0;
    n_checks++;
    if (leak) begin
      n_fail++;
      $display("FAIL ready_while_waiting: rx_ready got 1 expected 0");
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_busy: rx_ready got %b expected 1", rx_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_ready, instr0_fifo_wr, instr1_fifo_wr, wrdata_fifo_wr, process_iseq,
         loader_idle} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {rx_ready, instr0_fifo_wr,
               instr1_fifo_wr, wrdata_fifo_wr, process_iseq, loader_idle});
    end
    n_checks++;
    if (instr_fifo_din !== 32'd0 || wrdata_fifo_din !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_data: instr din %h wrdata lo %h expected 0", instr_fifo_din,
               wrdata_fifo_din[63:0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (loader_idle !== 1'b1 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: idle %b ready %b expected 1 1", loader_idle, rx_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_odd_seq();
    int l0 = n_launch;
    exp0.push_back(32'h1000_0000);
    exp1.push_back(32'h1000_0001);
    exp0.push_back(32'h1000_0002);
    exp1.push_back(NOP);
    for (int i = 0; i < 3; i++) send(32'h1000_0000 + i);
    send(END_W);
    run_dispatch();
    n_checks++;
    if (n_launch - l0 != 1 || exp0.size() != 0 || exp1.size() != 0) begin
      n_fail++;
      $display("FAIL odd_seq: launches %0d left0 %0d left1 %0d expected 1 0 0",
               n_launch - l0, exp0.size(), exp1.size());
    end
  endtask

  task automatic test_even_seq();
    int p0 = n_instr_push;
    exp0.push_back(32'h2000_00A0);
    exp1.push_back(32'h2000_00A1);
    send(32'h2000_00A0);
    send(32'h2000_00A1);
    send(END_W);
    run_dispatch();
    n_checks++;
    if (n_instr_push - p0 != 2) begin
      n_fail++;
      $display("FAIL even_push_count: got %0d expected 2", n_instr_push - p0);
    end
    n_checks++;
    if (launch_cyc != last_instr_cyc + 1) begin
      n_fail++;
      $display("FAIL even_launch_timing: launch cycle %0d expected %0d", launch_cyc,
               last_instr_cyc + 1);
    end
  endtask

  task automatic test_wrdata();
    logic [511:0] v = '0;
    int p0 = n_instr_push;
    bit stall_ok = 1'b1;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = k;
    expw.push_back(v);
    send(HDR_W);
    @(negedge clk);
    n_checks++;
    if (loader_idle !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_in_burst: got %b expected 0", loader_idle);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 15; k++) send(k);
    wrdata_fifo_full = 1'b1;
    rx_data  = 32'd15;
    rx_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) stall_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    wrdata_fifo_full = 1'b0;
    n_checks++;
    if (!stall_ok) begin
      n_fail++;
      $display("FAIL beat15_stall: rx_ready got 1 expected 0 with wrdata full");
    end
    send(32'd15);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (expw.size() != 0 || n_instr_push != p0) begin
      n_fail++;
      $display("FAIL wrdata_burst: pending %0d instr pushes %0d expected 0 0", expw.size(),
               n_instr_push - p0);
    end
  endtask

  task automatic test_full_stall();
    int stalls = 0;
    exp0.push_back(32'h3000_0000);
    exp1.push_back(32'h3000_0001);
    send(32'h3000_0000);
    instr1_fifo_full = 1'b1;
    rx_data  = 32'h3000_0001;
    rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rx_ready === 1'b0) stalls++;
      @(posedge clk);
      #1;
    end
    instr1_fifo_full = 1'b0;
    n_checks++;
    if (stalls != 5 || exp1.size() != 1) begin
      n_fail++;
      $display("FAIL full_stall: stalled %0d cycles pending1 %0d expected 5 1", stalls,
               exp1.size());
    end
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_6th: rx_ready got %b expected 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    send(END_W);
    run_dispatch();
    n_checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      n_fail++;
      $display("FAIL full_stall_drain: left0 %0d left1 %0d expected 0 0", exp0.size(),
               exp1.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [511:0] v = '0;
    int l0 = n_launch;
    send(HDR_W);
    for (int k = 0; k < 7; k++) send(32'hDEAD_0000 + k);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_ready, instr0_fifo_wr, instr1_fifo_wr, wrdata_fifo_wr, process_iseq,
         loader_idle} !== 6'b0 || wrdata_fifo_din !== 512'd0 || instr_fifo_din !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: ready %b wrdata lo %h instr din %h expected all 0",
               rx_ready, wrdata_fifo_din[63:0], instr_fifo_din);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'h0000_0100 + k;
    expw.push_back(v);
    send(HDR_W);
    for (int k = 0; k < 16; k++) send(32'h0000_0100 + k);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (expw.size() != 0 || n_launch != l0) begin
      n_fail++;
      $display("FAIL clean_burst: pending %0d launches %0d expected 0 0", expw.size(),
               n_launch - l0);
    end
  endtask

`ifdef ISEQ_LOADER_STATS_EN
  task automatic test_stats();
    for (int s = 0; s < 3; s++) begin
      exp0.push_back(32'h4000_0000 + 16 * s);
      exp1.push_back(32'h4000_0001 + 16 * s);
      exp0.push_back(32'h4000_0002 + 16 * s);
      exp1.push_back(NOP);
      for (int i = 0; i < 3; i++) send(32'h4000_0000 + 16 * s + i);
      send(END_W);
      run_dispatch();
    end
    n_checks++;
    if (stat_iseq_cnt !== 16'd3 || stat_instr_cnt !== 32'd9) begin
      n_fail++;
      $display("FAIL stats: iseq %0d instr %0d expected 3 9", stat_iseq_cnt, stat_instr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_odd_seq();
    test_even_seq();
    test_wrdata();
    test_full_stall();
    test_reset_mid_burst();
`ifdef ISEQ_LOADER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
